// File: rtl/m2vblkseq.sv
// MPEG-2 macroblock block sequencer: walks a macroblock's blocks through the dequantizer, all outputs registered.
// Optional M2VBLKSEQ_CHROMA422_EN adds mb_chroma422 (8-block 4:2:2 macroblocks); default build is 4:2:0 only.
module m2vblkseq (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       softreset,
    input  logic       mb_valid,
    output logic       mb_ready,
    input  logic [7:0] mb_cbp,
    input  logic       mb_intra,
    input  logic [4:0] mb_qscode,
`ifdef M2VBLKSEQ_CHROMA422_EN
    input  logic       mb_chroma422,
`endif
    input  logic       ready_isdq,
    input  logic       vld_eob,
    output logic       block_start,
    output logic       block_end,
    output logic       s1_enable,
    output logic       s1_coded,
    output logic       s1_mb_intra,
    output logic [4:0] s1_mb_qscode,
    output logic       s2_enable,
    output logic       s2_coded,
    output logic [2:0] blk_index,
    output logic       mb_done,
    output logic       seq_err,
    input  logic       qm_load_req,
    output logic       qm_load_gnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_QM    = 3'd1,
        S_SETUP = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_END   = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic       accept;
    logic       chroma_in;
    logic       last_blk;

    logic [7:0] cbp_q, cbp_d;
    logic       chroma_q, chroma_d;
    logic       mb_ready_q, mb_ready_d;
    logic       block_start_q, block_start_d;
    logic       block_end_q, block_end_d;
    logic       s1_enable_q, s1_enable_d;
    logic       s1_coded_q, s1_coded_d;
    logic       s1_mb_intra_q, s1_mb_intra_d;
    logic [4:0] s1_mb_qscode_q, s1_mb_qscode_d;
    logic       s2_enable_q, s2_enable_d;
    logic       s2_coded_q, s2_coded_d;
    logic [2:0] blk_index_q, blk_index_d;
    logic       mb_done_q, mb_done_d;
    logic       seq_err_q, seq_err_d;
    logic       qm_load_gnt_q, qm_load_gnt_d;
    logic [2:0] cbp_pos;
    logic       last_d;

`ifdef M2VBLKSEQ_CHROMA422_EN
    assign chroma_in = mb_chroma422;
`else
    assign chroma_in = 1'b0;
`endif

    assign last_blk = (blk_index_q == (chroma_q ? 3'd7 : 3'd5));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // mb_ready_q already reflects qm_load_req of the previous cycle; a live request still wins here
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (qm_load_req) begin
                    state_d = S_QM;
                end else if (mb_valid && mb_ready_q) begin
                    accept  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_QM:    if (!qm_load_req) state_d = S_IDLE;
            S_SETUP: if (ready_isdq) state_d = S_START;
            S_START: state_d = s2_coded_q ? S_RUN : S_END;
            S_RUN:   if (vld_eob) state_d = S_END;
            S_END:   state_d = last_blk ? S_IDLE : S_SETUP;
            default: state_d = S_IDLE;
        endcase
        if (softreset) begin
            state_d = S_IDLE;
            accept  = 1'b0;
        end
    end

    // Outputs are decoded from the next state so each registered pulse lines up with its state
    always_comb begin
        cbp_d          = cbp_q;
        chroma_d       = chroma_q;
        s1_mb_intra_d  = s1_mb_intra_q;
        s1_mb_qscode_d = s1_mb_qscode_q;
        blk_index_d    = blk_index_q;
        s1_coded_d     = s1_coded_q;
        s2_enable_d    = s2_enable_q;
        s2_coded_d     = s2_coded_q;

        if (accept) begin
            cbp_d          = mb_cbp;
            chroma_d       = chroma_in;
            s1_mb_intra_d  = mb_intra;
            s1_mb_qscode_d = mb_qscode;
            blk_index_d    = 3'd0;
        end else if (state_q == S_END && state_d == S_SETUP) begin
            blk_index_d = blk_index_q + 3'd1;
        end

        cbp_pos = chroma_d ? (3'd7 - blk_index_d) : (3'd5 - blk_index_d);
        last_d  = (blk_index_d == (chroma_d ? 3'd7 : 3'd5));

        if (state_d == S_SETUP) begin
            s1_coded_d = s1_mb_intra_d | cbp_d[cbp_pos];
        end
        if (state_q == S_SETUP && state_d == S_START) begin
            s2_enable_d = s1_enable_q;
            s2_coded_d  = s1_coded_q;
        end

        mb_ready_d    = (state_d == S_IDLE) && !qm_load_req;
        qm_load_gnt_d = (state_d == S_QM);
        s1_enable_d   = (state_d == S_SETUP);
        block_start_d = (state_d == S_START);
        block_end_d   = (state_d == S_END);
        mb_done_d     = (state_d == S_END) && last_d;
        seq_err_d     = seq_err_q | (vld_eob && state_q != S_RUN);

        if (softreset) begin
            cbp_d          = 8'd0;
            chroma_d       = 1'b0;
            s1_mb_intra_d  = 1'b0;
            s1_mb_qscode_d = 5'd0;
            blk_index_d    = 3'd0;
            s1_coded_d     = 1'b0;
            s2_enable_d    = 1'b0;
            s2_coded_d     = 1'b0;
            mb_ready_d     = 1'b0;
            qm_load_gnt_d  = 1'b0;
            s1_enable_d    = 1'b0;
            block_start_d  = 1'b0;
            block_end_d    = 1'b0;
            mb_done_d      = 1'b0;
            seq_err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cbp_q          <= 8'd0;
            chroma_q       <= 1'b0;
            s1_mb_intra_q  <= 1'b0;
            s1_mb_qscode_q <= 5'd0;
            blk_index_q    <= 3'd0;
            s1_coded_q     <= 1'b0;
            s2_enable_q    <= 1'b0;
            s2_coded_q     <= 1'b0;
            mb_ready_q     <= 1'b0;
            qm_load_gnt_q  <= 1'b0;
            s1_enable_q    <= 1'b0;
            block_start_q  <= 1'b0;
            block_end_q    <= 1'b0;
            mb_done_q      <= 1'b0;
            seq_err_q      <= 1'b0;
        end else begin
            cbp_q          <= cbp_d;
            chroma_q       <= chroma_d;
            s1_mb_intra_q  <= s1_mb_intra_d;
            s1_mb_qscode_q <= s1_mb_qscode_d;
            blk_index_q    <= blk_index_d;
            s1_coded_q     <= s1_coded_d;
            s2_enable_q    <= s2_enable_d;
            s2_coded_q     <= s2_coded_d;
            mb_ready_q     <= mb_ready_d;
            qm_load_gnt_q  <= qm_load_gnt_d;
            s1_enable_q    <= s1_enable_d;
            block_start_q  <= block_start_d;
            block_end_q    <= block_end_d;
            mb_done_q      <= mb_done_d;
            seq_err_q      <= seq_err_d;
        end
    end

    assign mb_ready     = mb_ready_q;
    assign block_start  = block_start_q;
    assign block_end    = block_end_q;
    assign s1_enable    = s1_enable_q;
    assign s1_coded     = s1_coded_q;
    assign s1_mb_intra  = s1_mb_intra_q;
    assign s1_mb_qscode = s1_mb_qscode_q;
    assign s2_enable    = s2_enable_q;
    assign s2_coded     = s2_coded_q;
    assign blk_index    = blk_index_q;
    assign mb_done      = mb_done_q;
    assign seq_err      = seq_err_q;
    assign qm_load_gnt  = qm_load_gnt_q;

endmodule
